// File: rtl/sram_arb_pkg.sv
// Shared defaults, grant encoding and address helper for the 1rw SRAM request arbiter.
package sram_arb_pkg;

    localparam int DEF_DATA_WIDTH = 128;
    localparam int DEF_DEPTH      = 257;
    localparam int DEF_ADDR_WIDTH = 9;
    localparam int DEF_RSP_DEPTH  = 3;

    typedef enum logic [1:0] {
        GRANT_NONE = 2'd0,
        GRANT_WR   = 2'd1,
        GRANT_RD   = 2'd2
    } grant_e;

    function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned depth);
        return (addr < depth);
    endfunction

endpackage

// File: rtl/sram_arb_rsp_fifo.sv
// Read-response buffer: circular storage of RSP_DEPTH words, pointers wrap modulo
// RSP_DEPTH so the depth need not be a power of two. Head reads as zero when empty.
module sram_arb_rsp_fifo #(
    parameter int DATA_WIDTH = 128,
    parameter int RSP_DEPTH  = 3,
    parameter int CNT_W      = $clog2(RSP_DEPTH + 1)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  i_push,
    input  logic [DATA_WIDTH-1:0] i_push_data,
    input  logic                  i_pop,
    output logic [DATA_WIDTH-1:0] o_head_data,
    output logic [CNT_W-1:0]      o_count
);
    localparam int PTR_W = (RSP_DEPTH > 1) ? $clog2(RSP_DEPTH) : 1;
    localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(RSP_DEPTH - 1);

    logic [DATA_WIDTH-1:0] r_mem [RSP_DEPTH];
    logic [PTR_W-1:0]      r_wr_ptr;
    logic [PTR_W-1:0]      r_rd_ptr;
    logic [CNT_W-1:0]      r_count;

    function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
        return (p == LAST_PTR) ? PTR_W'(0) : p + PTR_W'(1);
    endfunction

    // Storage write at the tail.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < RSP_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_push) begin
            r_mem[r_wr_ptr] <= i_push_data;
        end
    end

    // Pointer and occupancy bookkeeping; push and pop together keep the count.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (i_push) begin
                r_wr_ptr <= ptr_next(r_wr_ptr);
            end
            if (i_pop) begin
                r_rd_ptr <= ptr_next(r_rd_ptr);
            end
            case ({i_push, i_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign o_head_data = (r_count != '0) ? r_mem[r_rd_ptr] : '0;
    assign o_count     = r_count;

endmodule

// File: rtl/sram_1rw_req_arbiter.sv
// Round-robin write/read arbiter in front of a single-port SRAM with a credit-managed
// response buffer. Optional build macro SRAM_ARB_BOUNDS_CHECK_EN blocks out-of-range access.
module sram_1rw_req_arbiter
    import sram_arb_pkg::*;
#(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int DEPTH      = DEF_DEPTH,
    parameter int ADDR_WIDTH = DEF_ADDR_WIDTH,
    parameter int RSP_DEPTH  = DEF_RSP_DEPTH
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    input  logic                  rd_valid,
    output logic                  rd_ready,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    output logic                  rsp_valid,
    input  logic                  rsp_ready,
    output logic [DATA_WIDTH-1:0] rsp_data,
    output logic                  a_we,
    output logic                  a_re,
    output logic [ADDR_WIDTH-1:0] a_addr,
    output logic [DATA_WIDTH-1:0] a_data_in,
    input  logic [DATA_WIDTH-1:0] a_data_out
);
    localparam int CNT_W = $clog2(RSP_DEPTH + 1);

    if (RSP_DEPTH < 1 || (2 ** ADDR_WIDTH) < DEPTH) begin : g_bad_cfg
        $error("sram_1rw_req_arbiter: invalid DEPTH/ADDR_WIDTH/RSP_DEPTH combination");
    end

    logic [CNT_W-1:0]      w_count;
    logic [CNT_W:0]        w_used;
    logic                  w_credit_ok;
    logic                  w_rd_elig;
    logic                  w_contend;
    logic                  w_wr_ok;
    logic                  w_rd_ok;
    logic                  w_pop;
    logic [DATA_WIDTH-1:0] w_push_data;
    logic [DATA_WIDTH-1:0] w_head;
    grant_e                w_grant;
    grant_e                r_last_grant;
    logic                  r_inflight;
    logic                  r_inflight_zero;

    // Credits are computed purely from registered occupancy plus the in-flight read.
    assign w_used      = {1'b0, w_count} + {{CNT_W{1'b0}}, r_inflight};
    assign w_credit_ok = (w_used < (CNT_W + 1)'(RSP_DEPTH));
    assign w_rd_elig   = rd_valid && w_credit_ok;
    assign w_contend   = wr_valid && w_rd_elig;

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
    assign w_wr_ok = addr_in_range(32'(wr_addr), DEPTH);
    assign w_rd_ok = addr_in_range(32'(rd_addr), DEPTH);
`else
    assign w_wr_ok = 1'b1;
    assign w_rd_ok = 1'b1;
`endif

    // Arbitration: each ready only looks at the opposite channel's valid.
    always_comb begin
        wr_ready = 1'b0;
        rd_ready = 1'b0;
        w_grant  = GRANT_NONE;
        if (rst_n) begin
            wr_ready = !w_rd_elig || (r_last_grant == GRANT_RD);
            rd_ready = w_credit_ok && (!wr_valid || (r_last_grant == GRANT_WR));
        end else begin
            wr_ready = 1'b0;
            rd_ready = 1'b0;
        end
        if (wr_valid && wr_ready) begin
            w_grant = GRANT_WR;
        end else if (rd_valid && rd_ready) begin
            w_grant = GRANT_RD;
        end else begin
            w_grant = GRANT_NONE;
        end
    end

    // SRAM command, driven straight from this cycle's grant.
    always_comb begin
        a_we      = 1'b0;
        a_re      = 1'b0;
        a_addr    = '0;
        a_data_in = '0;
        if (rst_n) begin
            a_data_in = wr_data;
            case (w_grant)
                GRANT_WR: begin
                    a_we   = w_wr_ok;
                    a_addr = wr_addr;
                end
                GRANT_RD: begin
                    a_re   = w_rd_ok;
                    a_addr = rd_addr;
                end
                default: a_addr = '0;
            endcase
        end else begin
            a_data_in = '0;
        end
    end

    // Round-robin history moves only when both sides actually competed.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_last_grant <= GRANT_RD;
        end else if (w_contend) begin
            r_last_grant <= w_grant;
        end
    end

    // In-flight read tracking; a blocked out-of-range read returns zeros.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight      <= 1'b0;
            r_inflight_zero <= 1'b0;
        end else begin
            r_inflight      <= (w_grant == GRANT_RD);
            r_inflight_zero <= (w_grant == GRANT_RD) && !w_rd_ok;
        end
    end

    assign w_push_data = r_inflight_zero ? '0 : a_data_out;
    assign w_pop       = rsp_valid && rsp_ready;

    sram_arb_rsp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .RSP_DEPTH  (RSP_DEPTH),
        .CNT_W      (CNT_W)
    ) u_rsp_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_push      (r_inflight),
        .i_push_data (w_push_data),
        .i_pop       (w_pop),
        .o_head_data (w_head),
        .o_count     (w_count)
    );

    assign rsp_valid = (w_count != '0);
    assign rsp_data  = w_head;

endmodule

// File: tb/tb_sram_1rw_req_arbiter.sv
// Bench for sram_1rw_req_arbiter: directed tables and sequences plus random traffic
// checked against a transaction-level model (credits, round-robin, ordered responses).
module tb_sram_1rw_req_arbiter;
    localparam int DW    = 128;
    localparam int DEPTH = 257;
    localparam int AW    = 9;
    localparam int RSPD  = 3;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          wr_valid = 1'b0, rd_valid = 1'b0, rsp_ready = 1'b0;
    logic          wr_ready, rd_ready, rsp_valid, a_we, a_re;
    logic [AW-1:0] wr_addr = '0, rd_addr = '0, a_addr;
    logic [DW-1:0] wr_data = '0, rsp_data, a_data_in;
    logic [DW-1:0] a_data_out = '0;

    int n_chk  = 0;
    int n_pass = 0;

    always #5 clk = ~clk;

    sram_1rw_req_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_data(wr_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_data(rsp_data),
        .a_we(a_we), .a_re(a_re), .a_addr(a_addr), .a_data_in(a_data_in),
        .a_data_out(a_data_out)
    );

    // Behavioural 1rw SRAM: write lands at the edge, read data appears after the edge.
    logic [DW-1:0] sram [512];
    always @(posedge clk) begin
        if (a_we) sram[a_addr] <= a_data_in;
        if (a_re) a_data_out <= sram[a_addr];
    end

    task automatic chk1(input string name, input logic act, input logic exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %b expected %b", name, act, exp);
    endtask

    task automatic chki(input string name, input int act, input int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d", name, act, exp);
    endtask

    task automatic chkw(input string name, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", name, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic bit in_rng(input logic [AW-1:0] a);
`ifdef SRAM_ARB_BOUNDS_CHECK_EN
        return (int'(a) < DEPTH);
`else
        return (int'(a) < 512);
`endif
    endfunction

    // Transaction-level reference model.
    logic [DW-1:0] ref_mem [512];
    logic [DW-1:0] exp_q [$];
    int            outstanding = 0;
    bit            last_wr = 1'b0;

    always @(negedge clk) begin
        bit  elig;
        bit  contend;
        int  g;
        if (!rst_n) begin
            outstanding = 0;
            exp_q.delete();
            last_wr = 1'b0;
        end else begin
            elig    = rd_valid && (outstanding < RSPD);
            contend = wr_valid && elig;
            if (contend)       g = last_wr ? 2 : 1;
            else if (wr_valid) g = 1;
            else if (elig)     g = 2;
            else               g = 0;
            chk1("m_wr_hs", wr_valid && wr_ready, g == 1);
            chk1("m_rd_hs", rd_valid && rd_ready, g == 2);
            chk1("m_a_we", a_we, (g == 1) && in_rng(wr_addr));
            chk1("m_a_re", a_re, (g == 2) && in_rng(rd_addr));
            if (g == 0) chki("m_a_addr_idle", int'(a_addr), 0);
            if (g == 1 && in_rng(wr_addr)) begin
                chki("m_a_addr_wr", int'(a_addr), int'(wr_addr));
                chkw("m_a_data_in", a_data_in, wr_data);
            end
            if (g == 2 && in_rng(rd_addr)) chki("m_a_addr_rd", int'(a_addr), int'(rd_addr));
            if (rsp_valid && rsp_ready) begin
                if (exp_q.size() == 0) chk1("m_rsp_unexpected", 1'b1, 1'b0);
                else chkw("m_rsp_data", rsp_data, exp_q.pop_front());
                outstanding--;
            end
            if (g == 1 && in_rng(wr_addr)) ref_mem[wr_addr] = wr_data;
            if (g == 2) begin
                exp_q.push_back(in_rng(rd_addr) ? ref_mem[rd_addr] : '0);
                outstanding++;
            end
            if (contend) last_wr = (g == 1);
        end
    end

    typedef struct {
        logic wv;
        logic rv;
        logic ew;
        logic er;
    } vec_t;

    vec_t tbl [12];

    initial begin
        int            k;
        int            acc;
        int            pops;
        bit            got;
        bit            wr_acc;
        bit            rd_acc;
        logic [DW-1:0] first;
        logic [DW-1:0] x;

        for (int i = 0; i < 512; i++) begin
            sram[i]    = '0;
            ref_mem[i] = '0;
        end
        tbl[0]  = '{1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[2]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[3]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[4]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[5]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[6]  = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[7]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[8]  = '{1'b1, 1'b1, 1'b1, 1'b0};
        tbl[9]  = '{1'b0, 1'b1, 1'b0, 1'b1};
        tbl[10] = '{1'b1, 1'b1, 1'b0, 1'b1};
        tbl[11] = '{1'b1, 1'b0, 1'b1, 1'b0};

        // Reset values, with active requests present on the inputs.
        wr_valid = 1'b1; rd_valid = 1'b1; wr_addr = 9'd3; rd_addr = 9'd4;
        wr_data = {4{32'hDEADBEEF}}; rsp_ready = 1'b1;
        #12;
        chk1("rst_wr_ready", wr_ready, 1'b0);
        chk1("rst_rd_ready", rd_ready, 1'b0);
        chk1("rst_rsp_valid", rsp_valid, 1'b0);
        chkw("rst_rsp_data", rsp_data, '0);
        chk1("rst_a_we", a_we, 1'b0);
        chk1("rst_a_re", a_re, 1'b0);
        chki("rst_a_addr", int'(a_addr), 0);
        chkw("rst_a_data_in", a_data_in, '0);
        wr_valid = 1'b0; rd_valid = 1'b0;
        @(posedge clk); #1 rst_n = 1'b1;

        // Write then read address 5, response two cycles after read accept.
        wr_valid = 1'b1; wr_addr = 9'd5; wr_data = {16{8'hA5}};
        @(negedge clk); chk1("t1_wr_ready", wr_ready, 1'b1); chk1("t1_a_we", a_we, 1'b1);
        tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd5;
        @(negedge clk); chk1("t1_rd_ready", rd_ready, 1'b1); chk1("t1_a_re", a_re, 1'b1);
        tick(); rd_valid = 1'b0;
        @(negedge clk); chk1("t1_rsp_valid_t1", rsp_valid, 1'b0);
        tick();
        @(negedge clk); chk1("t1_rsp_valid_t2", rsp_valid, 1'b1);
        chkw("t1_rsp_data", rsp_data, {16{8'hA5}});
        tick();

        rst_n = 1'b0; @(posedge clk); @(posedge clk); #1 rst_n = 1'b1;

        // Arbitration table: alternation, and history only moving on contention.
        wr_addr = 9'd40; rd_addr = 9'd40; wr_data = {4{32'h1234_5678}};
        for (int i = 0; i < 12; i++) begin
            wr_valid = tbl[i].wv; rd_valid = tbl[i].rv;
            @(negedge clk);
            chk1($sformatf("tbl%0d_we", i), a_we, tbl[i].ew);
            chk1($sformatf("tbl%0d_re", i), a_re, tbl[i].er);
            tick();
        end
        wr_valid = 1'b0; rd_valid = 1'b0;

        // Preload addresses 10..14.
        for (int i = 0; i < 5; i++) begin
            wr_valid = 1'b1; wr_addr = 9'(10 + i); wr_data = {4{32'h1000_0000 + 32'(i)}};
            tick();
        end
        wr_valid = 1'b0;
        repeat (3) tick();

        // Backpressure: only RSP_DEPTH reads fit, then in-order drain and resume.
        rsp_ready = 1'b0; k = 0; acc = 0;
        rd_valid = 1'b1; rd_addr = 9'd10;
        for (int c = 0; c < 6; c++) begin
            @(negedge clk);
            if (rd_ready) begin acc++; k++; end
            tick();
            rd_addr = 9'(10 + k);
        end
        @(negedge clk);
        chki("bp_accepted", acc, RSPD);
        chk1("bp_rd_ready_low", rd_ready, 1'b0);
        chk1("bp_rsp_valid", rsp_valid, 1'b1);
        tick();
        rsp_ready = 1'b1; pops = 0; first = '0;
        for (int c = 0; c < 30 && (acc < 5 || pops < 5); c++) begin
            @(negedge clk);
            if (rd_valid && rd_ready) begin acc++; k++; end
            if (rsp_valid) begin
                if (pops == 0) first = rsp_data;
                pops++;
            end
            tick();
            if (k >= 5) rd_valid = 1'b0;
            else rd_addr = 9'(10 + k);
        end
        rd_valid = 1'b0;
        chki("bp_total_accepted", acc, 5);
        chki("bp_total_pops", pops, 5);
        chkw("bp_first_rsp", first, {4{32'h1000_0000}});

        // Write addr 7 then read addr 7 in the next cycle.
        x = {4{32'hC0DE_0007}};
        wr_valid = 1'b1; wr_addr = 9'd7; wr_data = x;
        @(negedge clk); chk1("t4_a_we", a_we, 1'b1);
        tick(); wr_valid = 1'b0; rd_valid = 1'b1; rd_addr = 9'd7;
        @(negedge clk); chk1("t4_a_re", a_re, 1'b1);
        tick(); rd_valid = 1'b0;
        got = 1'b0;
        for (int c = 0; c < 10 && !got; c++) begin
            @(negedge clk);
            if (rsp_valid) begin
                got = 1'b1;
                chkw("t4_rsp_data", rsp_data, x);
            end
            tick();
        end
        chk1("t4_rsp_seen", got, 1'b1);

        // Reset with one read in flight and two buffered.
        rsp_ready = 1'b0; rd_valid = 1'b1; rd_addr = 9'd11;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("t5_pre_rd_ready", rd_ready, 1'b1);
            if (c == 2) chk1("t5_pre_rsp_valid", rsp_valid, 1'b1);
            tick();
        end
        rd_valid = 1'b0; rst_n = 1'b0;
        #1;
        chk1("t5_rst_rsp_valid", rsp_valid, 1'b0);
        chkw("t5_rst_rsp_data", rsp_data, '0);
        chk1("t5_rst_rd_ready", rd_ready, 1'b0);
        @(posedge clk); #1 rst_n = 1'b1;
        rd_valid = 1'b1; rd_addr = 9'd12;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            chk1("t5_post_rd_ready", rd_ready, 1'b1);
            tick();
        end
        @(negedge clk); chk1("t5_post_full", rd_ready, 1'b0);
        tick(); rd_valid = 1'b0; rsp_ready = 1'b1;
        repeat (6) tick();

`ifdef SRAM_ARB_BOUNDS_CHECK_EN
        // Out-of-range read returns zero data; out-of-range write is handshaken only.
        rd_valid = 1'b1; rd_addr = 9'd300;
        @(negedge clk); chk1("oob_rd_ready", rd_ready, 1'b1); chk1("oob_a_re", a_re, 1'b0);
        tick(); rd_valid = 1'b0;
        tick();
        @(negedge clk); chk1("oob_rsp_valid", rsp_valid, 1'b1); chkw("oob_rsp_data", rsp_data, '0);
        tick();
        wr_valid = 1'b1; wr_addr = 9'd257; wr_data = {4{32'hFFFF_FFFF}};
        @(negedge clk); chk1("oob_wr_ready", wr_ready, 1'b1); chk1("oob_a_we", a_we, 1'b0);
        tick(); wr_valid = 1'b0;
        repeat (3) tick();
`endif

        // Random traffic against the model, with stable payloads while stalled.
        wr_acc = 1'b0; rd_acc = 1'b0;
        for (int c = 0; c < 1500; c++) begin
            if (!wr_valid || wr_acc) begin
                wr_valid = 1'($urandom_range(0, 1));
                wr_addr  = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, DEPTH - 1));
                wr_data  = {$urandom, $urandom, $urandom, $urandom};
            end
            if (!rd_valid || rd_acc) begin
                rd_valid = 1'($urandom_range(0, 1));
                rd_addr  = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(0, 7)) : 9'($urandom_range(0, DEPTH - 1));
            end
            rsp_ready = ($urandom_range(0, 3) != 0);
            @(negedge clk);
            wr_acc = wr_valid && wr_ready;
            rd_acc = rd_valid && rd_ready;
            tick();
        end

        wr_valid = 1'b0; rd_valid = 1'b0; rsp_ready = 1'b1;
        for (int c = 0; c < 20 && exp_q.size() != 0; c++) tick();
        repeat (2) tick();
        chki("drain_queue_empty", exp_q.size(), 0);
        @(negedge clk); chk1("drain_rsp_valid", rsp_valid, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
